subleq_sequencer: RTL and testbench

Instruction sequencer for the URISC core. It executes SUBLEQ (`mem[B] = mem[B] - mem[A]`; branch to C if the result is <= 0) through a single-port memory request/acknowledge interface. It sits directly downstream of the N-phase clock divider. It consumes the divider's one-hot phase vector as synchronous step enables in the same clock domain, not as clocks. Memory requests launch only on phase 0.

---
 rtl/subleq_sequencer_pkg.sv | 35 +++
 rtl/subleq_sequencer_if.sv | 22 ++
 rtl/subleq_sequencer_phase_check.sv | 19 +
 rtl/subleq_sequencer.sv | 133 +++++++++++++
 tb/tb_subleq_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/subleq_sequencer_pkg.sv
// Shared types and constants for the URISC SUBLEQ sequencer.
package urisc_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 8;

    // Branch target that means "stop" when the branch is taken.
    localparam logic [DEFAULT_ADDR_W-1:0] HALT_ADDR = '1;

    typedef enum logic [3:0] {
        IDLE,
        FETCH_A,
        FETCH_B,
        FETCH_C,
        READ_A,
        READ_B,
        WRITE,
        BRANCH,
        HALT
    } seq_state_t;

    // Successor of each memory-transaction state once its ack arrives.
    function automatic seq_state_t nextMemState(input seq_state_t s);
        case (s)
            FETCH_A: return FETCH_B;
            FETCH_B: return FETCH_C;
            FETCH_C: return READ_A;
            READ_A:  return READ_B;
            READ_B:  return WRITE;
            WRITE:   return BRANCH;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/subleq_sequencer_if.sv
// Single-port memory request/acknowledge bus between sequencer and memory.
interface subleq_mem_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              memReq;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic [DATA_W-1:0] memRdata;
    logic              memAck;

    modport master (
        output memReq, memWe, memAddr, memWdata,
        input  memRdata, memAck
    );

    modport slave (
        input  memReq, memWe, memAddr, memWdata,
        output memRdata, memAck
    );
endinterface

// File: rtl/subleq_sequencer_phase_check.sv
// Combinational one-hot test of the clock divider's phase vector.
module phase_onehot_check #(
    parameter int PHASES = 3
) (
    input  logic [PHASES-1:0] phaseIn,
    output logic              oneHot
);

    // Exactly one phase bit may be set in a legal cycle.
    always_comb begin
        int cnt;
        cnt = 0;
        for (int i = 0; i < PHASES; i++) begin
            cnt = cnt + int'(phaseIn[i]);
        end
        oneHot = (cnt == 1);
    end

endmodule

// File: rtl/subleq_sequencer.sv
// SUBLEQ instruction sequencer: fetch A/B/C, read operands, write the
// difference back and branch, one memory transaction per phase-0 slot.
module subleq_sequencer
    import urisc_pkg::*;
#(
    parameter int                DATA_W   = DEFAULT_DATA_W,
    parameter int                ADDR_W   = DEFAULT_ADDR_W,
    parameter int                PHASES   = 3,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clkIn,
    input  logic               rstN,
    input  logic [PHASES-1:0]  phaseIn,
    input  logic               start,
    subleq_mem_if.master       mem,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               halted,
    output logic               phaseErr
);

    seq_state_t        state;
    logic [ADDR_W-1:0] regA;
    logic [ADDR_W-1:0] regB;
    logic [ADDR_W-1:0] regC;
    logic [DATA_W-1:0] mA;
    logic [DATA_W-1:0] mB;
    logic [DATA_W-1:0] diff;
    logic              leq;
    logic              phaseOk;
    logic [ADDR_W-1:0] reqAddr;

    phase_onehot_check #(.PHASES(PHASES)) uPhaseCheck (
        .phaseIn (phaseIn),
        .oneHot  (phaseOk)
    );

    // Result of the instruction and its branch condition.
    always_comb begin
        diff = mB - mA;
        leq  = diff[DATA_W-1] | (diff == '0);
    end

    // Address each transaction state targets.
    always_comb begin
        reqAddr = pc;
        case (state)
            FETCH_A: reqAddr = pc;
            FETCH_B: reqAddr = pc + ADDR_W'(1);
            FETCH_C: reqAddr = pc + ADDR_W'(2);
            READ_A:  reqAddr = regA;
            READ_B:  reqAddr = regB;
            WRITE:   reqAddr = regB;
            default: reqAddr = pc;
        endcase
    end

    // Sticky record of any cycle whose phase vector was not one-hot.
    always_ff @(posedge clkIn or negedge rstN) begin
        if (!rstN) begin
            phaseErr <= 1'b0;
        end else if (!phaseOk) begin
            phaseErr <= 1'b1;
        end
    end

    // Main FSM: launches on phase 0, advances on the ack edge.
    always_ff @(posedge clkIn or negedge rstN) begin
        if (!rstN) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            regA         <= '0;
            regB         <= '0;
            regC         <= '0;
            mA           <= '0;
            mB           <= '0;
            mem.memReq   <= 1'b0;
            mem.memWe    <= 1'b0;
            mem.memAddr  <= '0;
            mem.memWdata <= '0;
            busy         <= 1'b0;
            halted       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FETCH_A;
                        busy  <= 1'b1;
                    end
                end
                FETCH_A, FETCH_B, FETCH_C, READ_A, READ_B, WRITE: begin
                    if (!mem.memReq) begin
                        if (phaseIn[0]) begin
                            mem.memReq  <= 1'b1;
                            mem.memAddr <= reqAddr;
                            mem.memWe   <= (state == WRITE);
                            if (state == WRITE) begin
                                mem.memWdata <= diff;
                            end
                        end
                    end else if (mem.memAck) begin
                        mem.memReq <= 1'b0;
                        case (state)
                            FETCH_A: regA <= mem.memRdata[ADDR_W-1:0];
                            FETCH_B: regB <= mem.memRdata[ADDR_W-1:0];
                            FETCH_C: regC <= mem.memRdata[ADDR_W-1:0];
                            READ_A:  mA   <= mem.memRdata;
                            READ_B:  mB   <= mem.memRdata;
                            default: ;
                        endcase
                        state <= nextMemState(state);
                    end
                end
                BRANCH: begin
                    if (leq && (regC == '1)) begin
                        state  <= HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        pc    <= leq ? regC : (pc + ADDR_W'(3));
                        state <= FETCH_A;
                    end
                end
                HALT: ;
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subleq_sequencer.sv
// Directed bench for subleq_sequencer with a behavioural memory responder.
module tb_subleq_sequencer;
    import urisc_pkg::*;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int PH = 3;

    logic          clkIn = 1'b0;
    logic          rstN;
    logic          start;
    logic [PH-1:0] phaseIn;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;
    logic          phaseErr;

    subleq_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    subleq_sequencer #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .PHASES   (PH),
        .RESET_PC (8'h00)
    ) dut (
        .clkIn    (clkIn),
        .rstN     (rstN),
        .phaseIn  (phaseIn),
        .start    (start),
        .mem      (bus.master),
        .pc       (pc),
        .busy     (busy),
        .halted   (halted),
        .phaseErr (phaseErr)
    );

    always #5 clkIn = ~clkIn;

    logic [DW-1:0] mem     [256];
    logic [DW-1:0] initMem [256];
    logic [AW-1:0] addrLog [64];
    logic          weLog   [64];
    logic [PH-1:0] edgePhase;
    int epoch = 0;
    int seenEpoch = 0;
    int txCount;
    int ackCount;
    int stabErr;
    int phaseViol;
    int ackLat = 1;
    int spurReq = 0;
    int spurDone = 0;
    int injReq = 0;
    int injDone = 0;
    int compared = 0;
    int mismatched = 0;

    // Divider model: rotating one-hot phase, with an optional illegal cycle.
    initial begin
        int ph;
        ph = 0;
        phaseIn = PH'(1);
        edgePhase = PH'(1);
        forever begin
            @(posedge clkIn);
            edgePhase = phaseIn;
            #1;
            ph = (ph + 1) % PH;
            if (injReq != injDone) begin
                phaseIn = 3'b011;
                injDone++;
            end else begin
                phaseIn = PH'(1) << ph;
            end
        end
    end

    // Memory responder: acks each request after ackLat cycles and logs it.
    initial begin
        logic          pending;
        int            cnt;
        logic [AW-1:0] lAddr;
        logic          lWe;
        logic [DW-1:0] lWd;
        pending = 1'b0;
        cnt = 0;
        lAddr = '0;
        lWe = 1'b0;
        lWd = '0;
        bus.memAck = 1'b0;
        bus.memRdata = '0;
        txCount = 0;
        ackCount = 0;
        stabErr = 0;
        phaseViol = 0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        forever begin
            @(posedge clkIn);
            #1;
            bus.memAck = 1'b0;
            if (epoch != seenEpoch) begin
                seenEpoch = epoch;
                pending = 1'b0;
                txCount = 0;
                ackCount = 0;
                stabErr = 0;
                phaseViol = 0;
                for (int i = 0; i < 256; i++) mem[i] = initMem[i];
            end else if (pending) begin
                cnt--;
                if (bus.memReq && (bus.memAddr !== lAddr || bus.memWe !== lWe ||
                                   bus.memWdata !== lWd)) stabErr++;
            end else if (bus.memReq) begin
                pending = 1'b1;
                cnt = ackLat;
                lAddr = bus.memAddr;
                lWe = bus.memWe;
                lWd = bus.memWdata;
                if (txCount < 64) begin
                    addrLog[txCount] = lAddr;
                    weLog[txCount] = lWe;
                end
                txCount++;
                if (!edgePhase[0]) phaseViol++;
            end else if (spurReq != spurDone) begin
                bus.memAck = 1'b1;
                spurDone++;
            end
            if (pending && cnt == 1) begin
                bus.memAck = 1'b1;
                if (lWe) mem[lAddr] = lWd;
                else bus.memRdata = mem[lAddr];
                ackCount++;
                pending = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clearProgram();
        for (int i = 0; i < 256; i++) initMem[i] = '0;
    endtask

    task automatic loadInstr(input logic [DW-1:0] mA, input logic [DW-1:0] mB, input logic [DW-1:0] c);
        clearProgram();
        initMem[0]  = 16'd10;
        initMem[1]  = 16'd11;
        initMem[2]  = c;
        initMem[10] = mA;
        initMem[11] = mB;
    endtask

    task automatic applyReset();
        rstN = 1'b0;
        epoch++;
        repeat (3) @(negedge clkIn);
        rstN = 1'b1;
        @(negedge clkIn);
    endtask

    task automatic applyStimulus();
        start = 1'b1;
        @(negedge clkIn);
        start = 1'b0;
    endtask

    task automatic waitAcks(input int n, input string tag);
        int budget;
        budget = 400;
        while (ackCount < n && budget > 0) begin
            @(negedge clkIn);
            budget--;
        end
        checkOutput(tag, ackCount, n);
    endtask

    task automatic runBasic(input int lat);
        ackLat = lat;
        loadInstr(16'd5, 16'd7, 16'd20);
        applyReset();
        applyStimulus();
        waitAcks(6, "basic acks");
        repeat (2) @(negedge clkIn);
        checkOutput("basic mem11", mem[11], 16'd2);
        checkOutput("basic pc", pc, 8'd3);
        checkOutput("basic txCount", txCount, 6);
        checkOutput("basic stable", stabErr, 0);
        checkOutput("basic phase0 launch", phaseViol, 0);
    endtask

    // Watchdog so a stuck DUT still terminates the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed test sequence.
    initial begin
        rstN = 1'b0;
        start = 1'b0;
        clearProgram();
        applyReset();

        checkOutput("reset memReq", bus.memReq, 1'b0);
        checkOutput("reset memWe", bus.memWe, 1'b0);
        checkOutput("reset memAddr", bus.memAddr, 8'h00);
        checkOutput("reset memWdata", bus.memWdata, 16'h0000);
        checkOutput("reset pc", pc, 8'h00);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset halted", halted, 1'b0);
        checkOutput("reset phaseErr", phaseErr, 1'b0);

        spurReq++;
        repeat (4) @(negedge clkIn);
        checkOutput("spurious busy", busy, 1'b0);
        checkOutput("spurious memReq", bus.memReq, 1'b0);
        checkOutput("spurious pc", pc, 8'h00);
        checkOutput("spurious txCount", txCount, 0);

        ackLat = 1;
        loadInstr(16'd5, 16'd7, 16'd20);
        applyReset();
        applyStimulus();
        checkOutput("single busy", busy, 1'b1);
        waitAcks(6, "single acks");
        repeat (2) @(negedge clkIn);
        checkOutput("single mem11", mem[11], 16'd2);
        checkOutput("single pc", pc, 8'd3);
        checkOutput("single phase0 launch", phaseViol, 0);
        checkOutput("single addr0", addrLog[0], 8'd0);
        checkOutput("single addr1", addrLog[1], 8'd1);
        checkOutput("single addr2", addrLog[2], 8'd2);
        checkOutput("single addr3", addrLog[3], 8'd10);
        checkOutput("single addr4", addrLog[4], 8'd11);
        checkOutput("single addr5", addrLog[5], 8'd11);
        checkOutput("single we4", weLog[4], 1'b0);
        checkOutput("single we5", weLog[5], 1'b1);

        runBasic(4);
        runBasic(9);

        ackLat = 1;
        loadInstr(16'd7, 16'd7, 16'd20);
        applyReset();
        applyStimulus();
        waitAcks(6, "taken acks");
        repeat (2) @(negedge clkIn);
        checkOutput("taken mem11", mem[11], 16'd0);
        checkOutput("taken pc", pc, 8'd20);

        loadInstr(16'd7, 16'd3, 16'h00FF);
        applyReset();
        applyStimulus();
        waitAcks(6, "halt acks");
        repeat (2) @(negedge clkIn);
        checkOutput("halt mem11", mem[11], 16'hFFFC);
        checkOutput("halt halted", halted, 1'b1);
        checkOutput("halt busy", busy, 1'b0);
        checkOutput("halt pc", pc, 8'd0);
        checkOutput("halt memReq", bus.memReq, 1'b0);
        applyStimulus();
        repeat (6) @(negedge clkIn);
        checkOutput("halt restart halted", halted, 1'b1);
        checkOutput("halt restart busy", busy, 1'b0);
        checkOutput("halt restart txCount", txCount, 6);
        checkOutput("halt restart pc", pc, 8'd0);

        clearProgram();
        initMem[0]     = 16'd30;
        initMem[1]     = 16'd31;
        initMem[2]     = 16'h00FE;
        initMem[30]    = 16'd5;
        initMem[31]    = 16'd5;
        initMem[8'hFE] = 16'd40;
        initMem[8'hFF] = 16'd41;
        initMem[40]    = 16'h0001;
        initMem[41]    = 16'h8000;
        applyReset();
        applyStimulus();
        waitAcks(6, "wrap first acks");
        repeat (2) @(negedge clkIn);
        checkOutput("wrap jump pc", pc, 8'hFE);
        waitAcks(12, "wrap second acks");
        repeat (2) @(negedge clkIn);
        checkOutput("wrap fetchA", addrLog[6], 8'hFE);
        checkOutput("wrap fetchB", addrLog[7], 8'hFF);
        checkOutput("wrap fetchC", addrLog[8], 8'h00);
        checkOutput("wrap diff", mem[41], 16'h7FFF);
        checkOutput("wrap pc", pc, 8'h01);

        ackLat = 4;
        loadInstr(16'd5, 16'd7, 16'd20);
        applyReset();
        applyStimulus();
        repeat (2) @(negedge clkIn);
        injReq++;
        repeat (3) @(negedge clkIn);
        checkOutput("phaseErr latch", phaseErr, 1'b1);
        checkOutput("phaseErr busy", busy, 1'b1);
        waitAcks(6, "phaseErr acks");
        repeat (2) @(negedge clkIn);
        checkOutput("phaseErr mem11", mem[11], 16'd2);
        checkOutput("phaseErr pc", pc, 8'd3);
        checkOutput("phaseErr sticky", phaseErr, 1'b1);
        begin
            int budget;
            budget = 400;
            while (txCount < 11 && budget > 0) begin
                @(negedge clkIn);
                budget--;
            end
        end
        checkOutput("readB reached", txCount, 11);
        checkOutput("readB memReq", bus.memReq, 1'b1);
        rstN = 1'b0;
        #1;
        checkOutput("rst memReq", bus.memReq, 1'b0);
        checkOutput("rst busy", busy, 1'b0);
        checkOutput("rst halted", halted, 1'b0);
        checkOutput("rst pc", pc, 8'h00);
        checkOutput("rst phaseErr", phaseErr, 1'b0);
        @(negedge clkIn);
        rstN = 1'b1;
        repeat (10) @(negedge clkIn);
        checkOutput("late ack delivered", ackCount, 11);
        checkOutput("late ack no launch", txCount, 11);
        checkOutput("late ack memReq", bus.memReq, 1'b0);
        checkOutput("late ack busy", busy, 1'b0);
        checkOutput("late ack pc", pc, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
